alu_op_sequencer: RTL and testbench

- Sequential front end that feeds the 16-bit combinational ALU (ports n, m, opc, c → f, zer, neg).
- Accepts operation commands over a valid/ready handshake, registers the operands and drives the ALU.
- Waits a programmable settle time, then captures the result and flags into output registers, presented over a valid/ready handshake.
- Keeps an accumulator so chained operations can use the previous result as operand m.

---
 rtl/alu_op_sequencer_pkg.sv | 14 +
 rtl/alu_op_sequencer.sv | 119 +++++++++++
 tb/tb_alu_op_sequencer.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_op_sequencer_pkg.sv
// Shared types and constants for the ALU operation sequencer.
package alu_op_sequencer_pkg;

  localparam int DATA_W = 16;
  localparam int OPC_W  = 3;

  // 2'd3 is unused and steers back to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_op_sequencer.sv
// Sequential front end for the combinational ALU: command handshake, settle delay, result capture.
// Optional sticky zero/negative flags are built when ALU_SEQ_STICKY_FLAGS_EN is defined.
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int W             = DATA_W,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_n,
  input  logic [W-1:0]     in_m,
  input  logic [OPC_W-1:0] in_opc,
  input  logic             in_c,
  input  logic             in_use_acc,
  output logic [W-1:0]     alu_n,
  output logic [W-1:0]     alu_m,
  output logic [OPC_W-1:0] alu_opc,
  output logic             alu_c,
  input  logic [W-1:0]     alu_f,
  input  logic             alu_zer,
  input  logic             alu_neg,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_f,
  output logic             out_zer,
  output logic             out_neg,
`ifdef ALU_SEQ_STICKY_FLAGS_EN
  input  logic             sticky_clr,
  output logic             sticky_zer,
  output logic             sticky_neg,
`endif
  output logic [W-1:0]     acc
);

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       capture;

  // The last settle cycle is the one that moves the ALU result into the output registers.
  assign capture = (state == EXEC) && (cnt == 4'd0);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      cnt       <= 4'd0;
      alu_n     <= '0;
      alu_m     <= '0;
      alu_opc   <= '0;
      alu_c     <= 1'b0;
      out_f     <= '0;
      out_zer   <= 1'b0;
      out_neg   <= 1'b0;
      acc       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            alu_n    <= in_n;
            alu_m    <= in_use_acc ? acc : in_m;
            alu_opc  <= in_opc;
            alu_c    <= in_c;
            cnt      <= CNT_LOAD;
            in_ready <= 1'b0;
            state    <= EXEC;
          end
        end
        EXEC: begin
          if (capture) begin
            out_f     <= alu_f;
            out_zer   <= alu_zer;
            out_neg   <= alu_neg;
            acc       <= alu_f;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          // in_ready rises only on entry to IDLE, so a command offered here waits a cycle.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

`ifdef ALU_SEQ_STICKY_FLAGS_EN
  // Clear takes priority over a capture landing on the same edge.
  always_ff @(posedge clk) begin
    if (rst || sticky_clr) begin
      sticky_zer <= 1'b0;
      sticky_neg <= 1'b0;
    end else if (capture) begin
      sticky_zer <= sticky_zer | alu_zer;
      sticky_neg <= sticky_neg | alu_neg;
    end
  end
`else
  // Sticky flag registers are not built in this configuration.
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench: two sequencers (settle 1 and 4) each driving a stub adder ALU,
// checked against a transaction-level model of results, accumulator and latency.
module tb_alu_op_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst        [2];
  logic        in_valid   [2];
  logic        in_ready   [2];
  logic [15:0] in_n       [2];
  logic [15:0] in_m       [2];
  logic [2:0]  in_opc     [2];
  logic        in_c       [2];
  logic        in_use_acc [2];
  logic [15:0] alu_n      [2];
  logic [15:0] alu_m      [2];
  logic [2:0]  alu_opc    [2];
  logic        alu_c      [2];
  logic [15:0] alu_f      [2];
  logic        alu_zer    [2];
  logic        alu_neg    [2];
  logic        out_valid  [2];
  logic        out_ready  [2];
  logic [15:0] out_f      [2];
  logic        out_zer    [2];
  logic        out_neg    [2];
  logic [15:0] acc        [2];
`ifdef ALU_SEQ_STICKY_FLAGS_EN
  logic        sticky_clr [2];
  logic        sticky_zer [2];
  logic        sticky_neg [2];
`endif

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int S = (g == 0) ? 1 : 4;

    assign alu_f[g]   = alu_n[g] + alu_m[g] + {15'd0, alu_c[g]};
    assign alu_zer[g] = (alu_f[g] == 16'd0);
    assign alu_neg[g] = alu_f[g][15];

    alu_op_sequencer #(.W(16), .SETTLE_CYCLES(S)) dut (
      .clk        (clk),
      .rst        (rst[g]),
      .in_valid   (in_valid[g]),
      .in_ready   (in_ready[g]),
      .in_n       (in_n[g]),
      .in_m       (in_m[g]),
      .in_opc     (in_opc[g]),
      .in_c       (in_c[g]),
      .in_use_acc (in_use_acc[g]),
      .alu_n      (alu_n[g]),
      .alu_m      (alu_m[g]),
      .alu_opc    (alu_opc[g]),
      .alu_c      (alu_c[g]),
      .alu_f      (alu_f[g]),
      .alu_zer    (alu_zer[g]),
      .alu_neg    (alu_neg[g]),
      .out_valid  (out_valid[g]),
      .out_ready  (out_ready[g]),
      .out_f      (out_f[g]),
      .out_zer    (out_zer[g]),
      .out_neg    (out_neg[g]),
`ifdef ALU_SEQ_STICKY_FLAGS_EN
      .sticky_clr (sticky_clr[g]),
      .sticky_zer (sticky_zer[g]),
      .sticky_neg (sticky_neg[g]),
`endif
      .acc        (acc[g])
    );
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: last result per instance and sticky flag history.
  logic [15:0] m_acc [2];
  logic        m_sz  [2];
  logic        m_sn  [2];

  function automatic int settle(input int u);
    return (u == 0) ? 1 : 4;
  endfunction

  task automatic chk(input string tag, input int u, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[u%0d] observed=%0h expected=%0h", tag, u, obs, exp);
    end
  endtask

  task automatic junk_inputs(input int u);
    in_n[u]       = 16'($urandom);
    in_m[u]       = 16'($urandom);
    in_opc[u]     = 3'($urandom);
    in_c[u]       = 1'($urandom);
    in_use_acc[u] = 1'($urandom);
  endtask

  task automatic check_sticky(input int u);
`ifdef ALU_SEQ_STICKY_FLAGS_EN
    chk("sticky_zer", u, sticky_zer[u], m_sz[u]);
    chk("sticky_neg", u, sticky_neg[u], m_sn[u]);
`endif
  endtask

  task automatic clear_sticky(input int u);
`ifdef ALU_SEQ_STICKY_FLAGS_EN
    @(negedge clk);
    sticky_clr[u] = 1'b1;
    @(negedge clk);
    sticky_clr[u] = 1'b0;
    m_sz[u] = 1'b0;
    m_sn[u] = 1'b0;
    check_sticky(u);
`endif
  endtask

  // One complete transaction: accept, settle, capture, hold under backpressure, release.
  task automatic do_op(input int u, input logic [15:0] n, input logic [15:0] m,
                       input logic [2:0] opc, input logic c, input logic ua, input int hold);
    logic [15:0] mu;
    logic [15:0] f;
    int j;
    mu = ua ? m_acc[u] : m;
    f  = n + mu + {15'd0, c};

    @(negedge clk);
    chk("in_ready_idle", u, in_ready[u], 1);
    in_valid[u]   = 1'b1;
    in_n[u]       = n;
    in_m[u]       = m;
    in_opc[u]     = opc;
    in_c[u]       = c;
    in_use_acc[u] = ua;
    @(negedge clk);
    in_valid[u] = 1'b0;
    junk_inputs(u);
    chk("alu_n", u, alu_n[u], n);
    chk("alu_m", u, alu_m[u], mu);
    chk("alu_opc", u, alu_opc[u], opc);
    chk("alu_c", u, alu_c[u], c);
    chk("in_ready_busy", u, in_ready[u], 0);

    j = 0;
    while (out_valid[u] !== 1'b1 && j < 40) begin
      chk("alu_hold", u, {alu_n[u], alu_m[u]}, {n, mu});
      @(negedge clk);
      j++;
    end
    chk("latency", u, j, settle(u));
    chk("out_f", u, out_f[u], f);
    chk("out_zer", u, out_zer[u], (f == 16'd0));
    chk("out_neg", u, out_neg[u], f[15]);
    chk("acc", u, acc[u], f);
    m_acc[u] = f;
    m_sz[u]  = m_sz[u] | (f == 16'd0);
    m_sn[u]  = m_sn[u] | f[15];
    check_sticky(u);

    for (int h = 0; h < hold; h++) begin
      in_valid[u] = 1'b1;
      junk_inputs(u);
      @(negedge clk);
      chk("bp_valid", u, out_valid[u], 1);
      chk("bp_out_f", u, out_f[u], f);
      chk("bp_in_ready", u, in_ready[u], 0);
    end

    out_ready[u] = 1'b1;
    in_valid[u]  = 1'b1;
    junk_inputs(u);
    @(negedge clk);
    out_ready[u] = 1'b0;
    in_valid[u]  = 1'b0;
    chk("release_valid", u, out_valid[u], 0);
    chk("release_ready", u, in_ready[u], 1);
    chk("no_bypass", u, {alu_n[u], alu_m[u]}, {n, mu});
  endtask

  task automatic reset_mid_exec(input int u);
    @(negedge clk);
    in_valid[u] = 1'b1;
    in_n[u]     = 16'h1234;
    in_m[u]     = 16'h0042;
    in_use_acc[u] = 1'b0;
    @(negedge clk);
    in_valid[u] = 1'b0;
    @(negedge clk);
    rst[u] = 1'b1;
    @(negedge clk);
    rst[u] = 1'b0;
    m_acc[u] = 16'd0;
    m_sz[u]  = 1'b0;
    m_sn[u]  = 1'b0;
    chk("rst_out_valid", u, out_valid[u], 0);
    chk("rst_in_ready", u, in_ready[u], 1);
    chk("rst_acc", u, acc[u], 0);
    chk("rst_alu_n", u, alu_n[u], 0);
    check_sticky(u);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("rst_discard", u, out_valid[u], 0);
    end
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      rst[u] = 1'b1;
      in_valid[u] = 1'b0;
      out_ready[u] = 1'b0;
      junk_inputs(u);
      m_acc[u] = 16'd0;
      m_sz[u]  = 1'b0;
      m_sn[u]  = 1'b0;
`ifdef ALU_SEQ_STICKY_FLAGS_EN
      sticky_clr[u] = 1'b0;
`endif
    end
    repeat (2) @(negedge clk);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    for (int u = 0; u < 2; u++) begin
      chk("reset_in_ready", u, in_ready[u], 1);
      chk("reset_out_valid", u, out_valid[u], 0);
      chk("reset_acc", u, acc[u], 0);
      chk("reset_out_f", u, out_f[u], 0);
      chk("reset_alu", u, {alu_n[u], alu_m[u], 13'd0, alu_opc[u]}, 0);
      check_sticky(u);
    end

    // Directed: basic, accumulator chain, zero and negative flags with backpressure.
    do_op(0, 16'd8, 16'd3, 3'd0, 1'b0, 1'b0, 0);
    do_op(0, 16'd5, 16'd2, 3'd0, 1'b0, 1'b0, 0);
    do_op(0, 16'd1, 16'hBEEF, 3'd0, 1'b0, 1'b1, 0);
    do_op(0, 16'd3, 16'hFFFD, 3'd0, 1'b0, 1'b0, 0);
    do_op(0, 16'hFFF8, 16'd3, 3'd0, 1'b0, 1'b0, 5);
    clear_sticky(0);

    // Long settle: accumulator use straight after reset sees zero.
    do_op(1, 16'd100, 16'd999, 3'd3, 1'b1, 1'b1, 2);
    do_op(1, 16'hFF9B, 16'd0, 3'd5, 1'b0, 1'b1, 0);
    do_op(1, 16'd7, 16'd9, 3'd1, 1'b0, 1'b0, 1);
    clear_sticky(1);

    for (int i = 0; i < 30; i++) begin
      for (int u = 0; u < 2; u++) begin
        do_op(u, 16'($urandom), 16'($urandom), 3'($urandom), 1'($urandom),
              1'($urandom), int'($urandom_range(0, 3)));
      end
    end

    reset_mid_exec(1);
    do_op(1, 16'd42, 16'h5555, 3'd2, 1'b1, 1'b1, 0);
    clear_sticky(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
